// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the fetch PC, requests 32-bit words from
// instruction memory over a req/ack handshake, buffers one instruction in
// the IR for the decode controller, applies branch redirects and flags a
// sticky error when memory fails to answer within MAX_WAIT cycles.
//
// Ports
//   Clk, Rst_n        clock, asynchronous active-low reset
//   IMem_Req/Addr     fetch request and word address (held until Ack)
//   IMem_Ack/Data     memory response and instruction word
//   Instr_Valid/Ready IR handshake toward the controller
//   Instruction       IR contents; Opcode = [31:26], Func = [5:0]
//   PC_Out, PC_Plus4  address of the IR instruction and that address + 4
//   Redirect/Target   branch redirect from execute
//   Fetch_Err         sticky memory-timeout flag
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        Clk,
    input  logic        Rst_n,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Ack,
    input  logic [31:0] IMem_Data,
    output logic        Instr_Valid,
    input  logic        Instr_Ready,
    output logic [31:0] Instruction,
    output logic [5:0]  Opcode,
    output logic [5:0]  Func,
    output logic [31:0] PC_Out,
    output logic [31:0] PC_Plus4,
    input  logic        Redirect,
    input  logic [31:0] Redirect_Target,
    output logic        Fetch_Err
);

    localparam int unsigned WAIT_W = 8;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_DRAIN,
        S_ERR
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         pc_q, pc_d;
    logic                req_q, req_d;
    logic [31:0]         addr_q, addr_d;
    logic                valid_q, valid_d;
    logic [31:0]         ir_q, ir_d;
    logic [31:0]         pc_out_q, pc_out_d;
    logic [31:0]         pc_plus4_q, pc_plus4_d;
    logic                err_q, err_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;

    logic [31:0]         target;
    logic [31:0]         pc_sel;
    logic [WAIT_W-1:0]   wait_inc;

    // Targets are forced word-aligned; pc_sel is the PC after this cycle's redirect.
    assign target   = Redirect_Target & 32'hFFFF_FFFC;
    assign pc_sel   = Redirect ? target : pc_q;
    assign wait_inc = wait_q + WAIT_W'(1);

    // State and datapath registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            valid_q    <= 1'b0;
            ir_q       <= 32'h0;
            pc_out_q   <= RESET_PC;
            pc_plus4_q <= RESET_PC + 32'd4;
            err_q      <= 1'b0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            ir_q       <= ir_d;
            pc_out_q   <= pc_out_d;
            pc_plus4_q <= pc_plus4_d;
            err_q      <= err_d;
            wait_q     <= wait_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        valid_d    = valid_q;
        ir_d       = ir_q;
        pc_out_d   = pc_out_q;
        pc_plus4_d = pc_plus4_q;
        err_d      = err_q;
        wait_d     = wait_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                req_d   = 1'b1;
                addr_d  = pc_q;
                wait_d  = '0;
            end

            S_FETCH: begin
                if (IMem_Ack) begin
                    wait_d = '0;
                    if (Redirect) begin
                        // Drop the returned word and re-request at the target.
                        pc_d   = target;
                        addr_d = target;
                    end else begin
                        ir_d       = IMem_Data;
                        pc_out_d   = pc_q;
                        pc_plus4_d = pc_q + 32'd4;
                        // Sequential PC is staged now so a redirect in HOLD can override it.
                        pc_d       = pc_q + 32'd4;
                        valid_d    = 1'b1;
                        req_d      = 1'b0;
                        state_d    = S_HOLD;
                    end
                end else if (Redirect) begin
                    pc_d    = target;
                    wait_d  = '0;
                    state_d = S_DRAIN;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == WAIT_LIMIT) begin
                        req_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end

            S_DRAIN: begin
                // Old request stays up until memory answers; the latest redirect wins.
                pc_d = pc_sel;
                if (IMem_Ack) begin
                    wait_d  = '0;
                    addr_d  = pc_sel;
                    state_d = S_FETCH;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == WAIT_LIMIT) begin
                        req_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end

            S_HOLD: begin
                if (Instr_Ready) begin
                    valid_d = 1'b0;
                    pc_d    = pc_sel;
                    addr_d  = pc_sel;
                    req_d   = 1'b1;
                    wait_d  = '0;
                    state_d = S_FETCH;
                end else if (Redirect) begin
                    pc_d = target;
                end
            end

            S_ERR: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
                err_d   = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign IMem_Req    = req_q;
    assign IMem_Addr   = addr_q;
    assign Instr_Valid = valid_q;
    assign Instruction = ir_q;
    assign Opcode      = ir_q[31:26];
    assign Func        = ir_q[5:0];
    assign PC_Out      = pc_out_q;
    assign PC_Plus4    = pc_plus4_q;
    assign Fetch_Err   = err_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed stimulus with literal
// expectations plus a transaction-level model compared every cycle.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          MAX_WAIT = 15;

    logic        Clk;
    logic        Rst_n;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic        IMem_Ack;
    logic [31:0] IMem_Data;
    logic        Instr_Valid;
    logic        Instr_Ready;
    logic [31:0] Instruction;
    logic [5:0]  Opcode;
    logic [5:0]  Func;
    logic [31:0] PC_Out;
    logic [31:0] PC_Plus4;
    logic        Redirect;
    logic [31:0] Redirect_Target;
    logic        Fetch_Err;

    int n_pass  = 0;
    int n_total = 0;

    instruction_fetch_unit #(
        .RESET_PC (RESET_PC),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .Clk             (Clk),
        .Rst_n           (Rst_n),
        .IMem_Req        (IMem_Req),
        .IMem_Addr       (IMem_Addr),
        .IMem_Ack        (IMem_Ack),
        .IMem_Data       (IMem_Data),
        .Instr_Valid     (Instr_Valid),
        .Instr_Ready     (Instr_Ready),
        .Instruction     (Instruction),
        .Opcode          (Opcode),
        .Func            (Func),
        .PC_Out          (PC_Out),
        .PC_Plus4        (PC_Plus4),
        .Redirect        (Redirect),
        .Redirect_Target (Redirect_Target),
        .Fetch_Err       (Fetch_Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- transaction-level model ----------------
    // Tracks what is outstanding at memory, what the next fetch PC is and
    // whether an instruction is buffered, rather than named states.
    bit          m_started, m_busy, m_drain, m_have, m_err;
    int          m_wait;
    logic [31:0] m_addr, m_next, m_ir, m_pcout;

    task automatic model_reset();
        m_started = 0; m_busy = 0; m_drain = 0; m_have = 0; m_err = 0;
        m_wait = 0;
        m_addr = RESET_PC; m_next = RESET_PC; m_ir = 32'h0; m_pcout = RESET_PC;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        tgt = Redirect_Target & 32'hFFFF_FFFC;
        if (!m_started) begin
            m_started = 1; m_busy = 1; m_addr = m_next; m_wait = 0;
        end else if (m_err) begin
            // dead until reset
        end else if (m_busy) begin
            if (IMem_Ack) begin
                m_wait = 0;
                if (m_drain) begin
                    if (Redirect) m_next = tgt;
                    m_drain = 0;
                    m_addr = m_next;
                end else if (Redirect) begin
                    m_next = tgt;
                    m_addr = tgt;
                end else begin
                    m_ir = IMem_Data; m_pcout = m_addr; m_next = m_addr + 32'd4;
                    m_have = 1; m_busy = 0;
                end
            end else if (Redirect && !m_drain) begin
                m_drain = 1; m_next = tgt; m_wait = 0;
            end else begin
                if (Redirect) m_next = tgt;
                m_wait++;
                if (m_wait == MAX_WAIT) begin
                    m_err = 1; m_busy = 0;
                end
            end
        end else if (m_have) begin
            if (Instr_Ready) begin
                if (Redirect) m_next = tgt;
                m_have = 0; m_busy = 1; m_addr = m_next; m_wait = 0;
            end else if (Redirect) begin
                m_next = tgt;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge Clk or negedge Rst_n);
            if (!Rst_n) model_reset();
            else model_step();
        end
    end

    // Every-cycle comparison against the model
    initial begin
        logic [31:0] ir_v;
        forever begin
            @(negedge Clk);
            ir_v = m_ir;
            chk("req",      32'(IMem_Req),    32'(m_busy));
            chk("addr",     IMem_Addr,        m_addr);
            chk("valid",    32'(Instr_Valid), 32'(m_have));
            chk("instr",    Instruction,      ir_v);
            chk("opcode",   32'(Opcode),      32'(ir_v[31:26]));
            chk("func",     32'(Func),        32'(ir_v[5:0]));
            chk("pc_out",   PC_Out,           m_pcout);
            chk("pc_plus4", PC_Plus4,         m_pcout + 32'd4);
            chk("err",      32'(Fetch_Err),   32'(m_err));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic nxt();
        @(negedge Clk);
        #1;
    endtask

    task automatic drive(input logic ack, input logic [31:0] data, input logic rdy,
                         input logic redir, input logic [31:0] tgt);
        IMem_Ack = ack; IMem_Data = data; Instr_Ready = rdy;
        Redirect = redir; Redirect_Target = tgt;
    endtask

    initial begin
        int n;
        Rst_n = 1'b0;
        drive(0, 32'h0, 0, 0, 32'h0);
        repeat (2) nxt();
        chk("rst_req",   32'(IMem_Req), 32'd0);
        chk("rst_addr",  IMem_Addr, RESET_PC);
        chk("rst_valid", 32'(Instr_Valid), 32'd0);
        chk("rst_err",   32'(Fetch_Err), 32'd0);
        Rst_n = 1'b1;

        // Basic fetch with single-cycle ack, then consume
        nxt(); chk("t1_req", 32'(IMem_Req), 32'd1); chk("t1_addr", IMem_Addr, 32'h0);
        drive(1, 32'h2008_0005, 0, 0, 32'h0);
        nxt(); chk("t1_valid", 32'(Instr_Valid), 32'd1); chk("t1_opc", 32'(Opcode), 32'h08);
        chk("t1_func", 32'(Func), 32'h05); chk("t1_pcout", PC_Out, 32'h0);
        chk("t1_plus4", PC_Plus4, 32'h4); chk("t1_req_off", 32'(IMem_Req), 32'd0);
        drive(0, 32'h0, 1, 0, 32'h0);
        nxt(); chk("t1_next_addr", IMem_Addr, 32'h4); chk("t1_next_req", 32'(IMem_Req), 32'd1);
        drive(0, 32'h0, 0, 0, 32'h0);

        // Ack delayed: request held stable
        for (int i = 0; i < 3; i++) begin
            nxt(); chk("t2_req", 32'(IMem_Req), 32'd1); chk("t2_addr", IMem_Addr, 32'h4);
            chk("t2_err", 32'(Fetch_Err), 32'd0);
        end
        drive(1, 32'h0123_4567, 0, 0, 32'h0);
        nxt(); chk("t2_instr", Instruction, 32'h0123_4567); chk("t2_pcout", PC_Out, 32'h4);
        drive(1, 32'hFFFF_FFFF, 0, 0, 32'h0);     // stray ack while holding
        nxt(); chk("t2_stray", Instruction, 32'h0123_4567); chk("t2_req_off", 32'(IMem_Req), 32'd0);
        drive(0, 32'h0, 1, 1, 32'h10);

        // Redirect mid-fetch drains the old request
        nxt(); chk("t3_addr10", IMem_Addr, 32'h10);
        drive(0, 32'h0, 0, 1, 32'h40);
        nxt(); chk("t3_drain_addr", IMem_Addr, 32'h10); chk("t3_drain_req", 32'(IMem_Req), 32'd1);
        drive(0, 32'h0, 0, 0, 32'h0);
        nxt(); drive(1, 32'hDEAD_BEEF, 0, 0, 32'h0);
        nxt(); chk("t3_dropped", 32'(Instr_Valid), 32'd0); chk("t3_addr40", IMem_Addr, 32'h40);
        drive(1, 32'h8C00_0001, 0, 0, 32'h0);
        nxt(); chk("t3_pcout", PC_Out, 32'h40); chk("t3_opc", 32'(Opcode), 32'h23);
        drive(0, 32'h0, 0, 1, 32'h20);            // redirect while holding, not consumed
        nxt(); chk("t4_hold_valid", 32'(Instr_Valid), 32'd1); chk("t4_hold_pc", PC_Out, 32'h40);
        drive(0, 32'h0, 1, 0, 32'h0);
        nxt(); chk("t4_applied", IMem_Addr, 32'h20);
        drive(1, 32'h0000_0022, 0, 0, 32'h0);
        nxt(); chk("t4_pcout20", PC_Out, 32'h20);
        drive(0, 32'h0, 1, 1, 32'h103);
        nxt(); chk("t4_addr100", IMem_Addr, 32'h100);
        drive(1, 32'h1111_1111, 0, 1, 32'h200);   // ack and redirect together
        nxt(); chk("t4_addr200", IMem_Addr, 32'h200); chk("t4_novalid", 32'(Instr_Valid), 32'd0);
        drive(1, 32'h2222_2222, 0, 0, 32'h0);
        nxt(); chk("t4_pc200", PC_Out, 32'h200); chk("t4_plus4", PC_Plus4, 32'h204);

        // PC wrap
        drive(0, 32'h0, 1, 1, 32'hFFFF_FFFC);
        nxt(); chk("t6_addr_top", IMem_Addr, 32'hFFFF_FFFC);
        drive(1, 32'h3333_3333, 0, 0, 32'h0);
        nxt(); chk("t6_pc_top", PC_Out, 32'hFFFF_FFFC); chk("t6_plus4_wrap", PC_Plus4, 32'h0);
        drive(0, 32'h0, 1, 0, 32'h0);
        nxt(); chk("t6_wrap_addr", IMem_Addr, 32'h0); chk("t6_wrap_req", 32'(IMem_Req), 32'd1);
        drive(0, 32'h0, 0, 0, 32'h0);

        // Timeout
        n = 0;
        while (IMem_Req && n < 40) begin
            n++;
            nxt();
        end
        chk("t5_req_cycles", 32'(n), 32'd15);
        chk("t5_err", 32'(Fetch_Err), 32'd1);
        chk("t5_req_off", 32'(IMem_Req), 32'd0);
        drive(1, 32'h4444_4444, 1, 1, 32'h80);
        repeat (3) nxt();
        chk("t5_sticky", 32'(Fetch_Err), 32'd1);
        chk("t5_ack_ign", Instruction, 32'h3333_3333);
        chk("t5_valid", 32'(Instr_Valid), 32'd0);
        drive(0, 32'h0, 0, 0, 32'h0);

        // Reset pulse clears the error
        #2 Rst_n = 1'b0;
        nxt(); chk("t5_clr_err", 32'(Fetch_Err), 32'd0);
        #2 Rst_n = 1'b1;
        nxt(); nxt(); chk("t6_refetch", IMem_Addr, 32'h0); chk("t6_refetch_req", 32'(IMem_Req), 32'd1);
        drive(1, 32'h5555_5555, 0, 0, 32'h0);
        nxt(); drive(0, 32'h0, 1, 1, 32'h80);
        nxt(); chk("t6_addr80", IMem_Addr, 32'h80);
        drive(0, 32'h0, 0, 0, 32'h0);

        // Asynchronous reset mid-fetch acts immediately
        #2 Rst_n = 1'b0;
        #1;
        chk("t6_async_req", 32'(IMem_Req), 32'd0);
        chk("t6_async_addr", IMem_Addr, RESET_PC);
        chk("t6_async_valid", 32'(Instr_Valid), 32'd0);
        nxt();
        #2 Rst_n = 1'b1;
        repeat (2) nxt();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
